// File: rtl/tanimoto_seq_ctrl.sv
// Run-level sequencer for tanimoto_top: threshold load, beat streaming, ID-pair drain, done/error.
// Optional drain watchdog enabled by defining TANIMOTO_CTRL_TIMEOUT_EN.
module tanimoto_seq_ctrl #(
  parameter int BUS_WIDTH      = 128,
  parameter int VECTOR_WIDTH   = 920,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH),
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_Start,
  input  logic                 i_Load_Thr,
  input  logic [31:0]          i_NumBeats,
  input  logic [CNT_WIDTH:0]   i_Thr_Data,
  input  logic                 i_Thr_Valid,
  output logic                 o_Thr_Ready,
  output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
  output logic [CNT_WIDTH:0]   o_BRAM_Din,
  output logic                 o_BRAM_En,
  output logic                 o_BRAM_WrEn,
  input  logic [BUS_WIDTH-1:0] i_Src_Vector,
  input  logic                 i_Src_Empty,
  output logic                 o_Src_Read,
  output logic [BUS_WIDTH-1:0] o_Vector,
  output logic                 o_Valid,
  output logic                 o_Last,
  input  logic                 i_Core_Read,
  input  logic                 i_IDPair_Ready,
  input  logic                 i_IDPair_Last,
  output logic                 o_IDPair_Read,
  input  logic                 i_Sink_Ready,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Error,
  output logic [31:0]          o_PairCount
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_THR = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               r_state;
  logic [31:0]          r_num_beats;
  logic [31:0]          r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_thr_cnt;
  logic [31:0]          r_pair_cnt;
  logic                 r_last_seen;
  logic [CNT_WIDTH-1:0] r_bram_addr;
  logic [CNT_WIDTH:0]   r_bram_din;
  logic                 r_bram_wren;

  logic w_thr_accept;
  logic w_thr_final;
  logic w_valid;
  logic w_beat;
  logic w_last;
  logic w_pair_rd;
  logic w_pair;

  assign w_thr_accept  = i_Thr_Valid && (r_state == S_LOAD_THR);
  assign w_thr_final   = (r_thr_cnt == CNT_WIDTH'(VECTOR_WIDTH - 1));
  assign w_valid       = (r_state == S_STREAM) && !i_Src_Empty;
  assign w_beat        = w_valid && i_Core_Read;
  assign w_last        = w_valid && (r_beat_cnt == (r_num_beats - 32'd1));
  assign w_pair_rd     = i_Sink_Ready && ((r_state == S_STREAM) || (r_state == S_DRAIN));
  assign w_pair        = w_pair_rd && i_IDPair_Ready;

  assign o_Thr_Ready   = (r_state == S_LOAD_THR);
  assign o_BRAM_Addr   = r_bram_addr;
  assign o_BRAM_Din    = r_bram_din;
  assign o_BRAM_En     = 1'b1;
  assign o_BRAM_WrEn   = r_bram_wren;
  assign o_Vector      = i_Src_Vector;
  assign o_Valid       = w_valid;
  assign o_Src_Read    = w_beat;
  assign o_Last        = w_last;
  assign o_IDPair_Read = w_pair_rd;
  assign o_Busy        = (r_state != S_IDLE);
  assign o_Done        = (r_state == S_DONE);
  assign o_PairCount   = r_pair_cnt;

`ifdef TANIMOTO_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_error;
  assign o_Error = r_error;
`else
  assign o_Error = 1'b0;
`endif

  // Run sequencer: state, counters and the registered BRAM write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_num_beats <= 32'd0;
      r_beat_cnt  <= 32'd0;
      r_thr_cnt   <= '0;
      r_pair_cnt  <= 32'd0;
      r_last_seen <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_bram_wren <= 1'b0;
`ifdef TANIMOTO_CTRL_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_bram_wren <= 1'b0;
      if (w_pair) begin
        r_pair_cnt <= r_pair_cnt + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_num_beats <= i_NumBeats;
            r_beat_cnt  <= 32'd0;
            r_thr_cnt   <= '0;
            r_pair_cnt  <= 32'd0;
            r_last_seen <= 1'b0;
`ifdef TANIMOTO_CTRL_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
            if (i_Load_Thr) begin
              r_state <= S_LOAD_THR;
            end else if (i_NumBeats == 32'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_LOAD_THR: begin
          if (w_thr_accept) begin
            r_bram_wren <= 1'b1;
            r_bram_addr <= r_thr_cnt;
            r_bram_din  <= i_Thr_Data;
            r_thr_cnt   <= r_thr_cnt + CNT_WIDTH'(1);
            if (w_thr_final) begin
              r_state <= (r_num_beats == 32'd0) ? S_DONE : S_STREAM;
            end
          end
        end
        S_STREAM: begin
`ifdef TANIMOTO_CTRL_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          // A last pair seen while still streaming lets DRAIN finish immediately
          if (w_pair && i_IDPair_Last) begin
            r_last_seen <= 1'b1;
          end
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((w_pair && i_IDPair_Last) || r_last_seen) begin
            r_state <= S_DONE;
          end
`ifdef TANIMOTO_CTRL_TIMEOUT_EN
          else if (w_pair) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tanimoto_seq_ctrl.sv
// Directed bench for tanimoto_seq_ctrl: cycle vector table plus hand-written multi-cycle runs.
// Define TANIMOTO_CTRL_TIMEOUT_EN to also exercise the drain watchdog.
module tb_tanimoto_seq_ctrl;

  localparam int BW = 128;
  localparam int VW = 920;
  localparam int CW = $clog2(VW);

  logic          clk;
  logic          rstn;
  logic          i_Start;
  logic          i_Load_Thr;
  logic [31:0]   i_NumBeats;
  logic [CW:0]   i_Thr_Data;
  logic          i_Thr_Valid;
  logic          o_Thr_Ready;
  logic [CW-1:0] o_BRAM_Addr;
  logic [CW:0]   o_BRAM_Din;
  logic          o_BRAM_En;
  logic          o_BRAM_WrEn;
  logic [BW-1:0] i_Src_Vector;
  logic          i_Src_Empty;
  logic          o_Src_Read;
  logic [BW-1:0] o_Vector;
  logic          o_Valid;
  logic          o_Last;
  logic          i_Core_Read;
  logic          i_IDPair_Ready;
  logic          i_IDPair_Last;
  logic          o_IDPair_Read;
  logic          i_Sink_Ready;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Error;
  logic [31:0]   o_PairCount;

  int n_checks = 0;
  int n_fail   = 0;

  tanimoto_seq_ctrl #(
    .BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn), .i_Start(i_Start), .i_Load_Thr(i_Load_Thr),
    .i_NumBeats(i_NumBeats), .i_Thr_Data(i_Thr_Data), .i_Thr_Valid(i_Thr_Valid),
    .o_Thr_Ready(o_Thr_Ready), .o_BRAM_Addr(o_BRAM_Addr), .o_BRAM_Din(o_BRAM_Din),
    .o_BRAM_En(o_BRAM_En), .o_BRAM_WrEn(o_BRAM_WrEn), .i_Src_Vector(i_Src_Vector),
    .i_Src_Empty(i_Src_Empty), .o_Src_Read(o_Src_Read), .o_Vector(o_Vector),
    .o_Valid(o_Valid), .o_Last(o_Last), .i_Core_Read(i_Core_Read),
    .i_IDPair_Ready(i_IDPair_Ready), .i_IDPair_Last(i_IDPair_Last),
    .o_IDPair_Read(o_IDPair_Read), .i_Sink_Ready(i_Sink_Ready), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Error(o_Error), .o_PairCount(o_PairCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_Start = 1'b0; i_Load_Thr = 1'b0; i_NumBeats = 32'd0;
    i_Thr_Data = '0; i_Thr_Valid = 1'b0; i_Src_Vector = '0; i_Src_Empty = 1'b1;
    i_Core_Read = 1'b0; i_IDPair_Ready = 1'b0; i_IDPair_Last = 1'b0; i_Sink_Ready = 1'b0;
  endtask

  typedef struct packed {
    logic st; logic ld; logic [31:0] nb;
    logic emp; logic crd; logic ipr; logic ipl; logic snk;
    logic busy; logic vld; logic lst; logic srd; logic iprd; logic done;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic st, ld, input logic [31:0] nb,
                              input logic emp, crd, ipr, ipl, snk,
                              input logic busy, vld, lst, srd, iprd, done,
                              input logic [31:0] pc);
    vec_t v;
    v.st = st; v.ld = ld; v.nb = nb; v.emp = emp; v.crd = crd; v.ipr = ipr;
    v.ipl = ipl; v.snk = snk; v.busy = busy; v.vld = vld; v.lst = lst;
    v.srd = srd; v.iprd = iprd; v.done = done; v.pc = pc;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    int beats, pairs, cyc, accepted, prev_k, wr_cnt, n_last, n_pop;
    logic prev_acc;

    //        st ld nb   emp crd ipr ipl snk  busy vld lst srd iprd done pc
    tbl[0]  = mk(1, 0, 3,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  0, 1, 0, 0, 1,   1, 1, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0, 1, 0, 1,   1, 1, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0,  1, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0,  0, 1, 0, 0, 1,   1, 1, 0, 1, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0,  0, 1, 1, 0, 1,   1, 1, 1, 1, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0,  0, 1, 1, 1, 0,   1, 0, 0, 0, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0,  0, 1, 1, 1, 1,   1, 0, 0, 0, 1, 0, 2);
    tbl[8]  = mk(0, 0, 0,  0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 1, 3);
    tbl[9]  = mk(0, 0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3);
    tbl[10] = mk(1, 0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 0,  1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 1,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,  0, 1, 1, 1, 1,   1, 1, 1, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,  1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1);
    tbl[16] = mk(0, 0, 0,  1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);

    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", o_Busy, 0);        check("rst_done", o_Done, 0);
    check("rst_error", o_Error, 0);      check("rst_pc", o_PairCount, 0);
    check("rst_bram_en", o_BRAM_En, 1);  check("rst_wren", o_BRAM_WrEn, 0);
    check("rst_addr", o_BRAM_Addr, 0);   check("rst_din", o_BRAM_Din, 0);
    check("rst_thr_ready", o_Thr_Ready, 0);
    check("rst_valid", o_Valid, 0);      check("rst_src_read", o_Src_Read, 0);
    check("rst_last", o_Last, 0);        check("rst_idpair_read", o_IDPair_Read, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Short run, held beats, ignored start, zero-beat run, last pair seen during STREAM
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      i_Start = tbl[i].st; i_Load_Thr = tbl[i].ld; i_NumBeats = tbl[i].nb;
      i_Src_Empty = tbl[i].emp; i_Core_Read = tbl[i].crd; i_IDPair_Ready = tbl[i].ipr;
      i_IDPair_Last = tbl[i].ipl; i_Sink_Ready = tbl[i].snk;
      i_Src_Vector = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("t%0d_busy", i), o_Busy, tbl[i].busy);
      check($sformatf("t%0d_valid", i), o_Valid, tbl[i].vld);
      check($sformatf("t%0d_last", i), o_Last, tbl[i].lst);
      check($sformatf("t%0d_src_read", i), o_Src_Read, tbl[i].srd);
      check($sformatf("t%0d_idpair_read", i), o_IDPair_Read, tbl[i].iprd);
      check($sformatf("t%0d_done", i), o_Done, tbl[i].done);
      check($sformatf("t%0d_pc", i), o_PairCount, tbl[i].pc);
      check($sformatf("t%0d_wren", i), o_BRAM_WrEn, 0);
      check($sformatf("t%0d_vector", i), o_Vector, i_Src_Vector);
    end
    @(negedge clk);
    idle_inputs();

    // Threshold load with gaps in the valid stream
    i_Start = 1'b1; i_Load_Thr = 1'b1; i_NumBeats = 32'd978;
    @(negedge clk);
    idle_inputs();
    accepted = 0; prev_acc = 1'b0; prev_k = 0; wr_cnt = 0; cyc = 0;
    while (accepted < VW && cyc < 5000) begin
      i_Thr_Valid = ((cyc % 3) != 2);
      i_Thr_Data = (CW+1)'(accepted + 1);
      #1;
      check("load_thr_ready", o_Thr_Ready, 1);
      check("load_wren", o_BRAM_WrEn, prev_acc);
      if (o_BRAM_WrEn) begin
        wr_cnt++;
        check("load_addr", o_BRAM_Addr, prev_k);
        check("load_din", o_BRAM_Din, prev_k + 1);
      end
      prev_acc = i_Thr_Valid && o_Thr_Ready;
      prev_k = accepted;
      if (prev_acc) accepted++;
      cyc++;
      @(negedge clk);
    end
    i_Thr_Valid = 1'b0; i_Src_Empty = 1'b0; i_Core_Read = 1'b0;
    #1;
    if (o_BRAM_WrEn) wr_cnt++;
    check("load_final_wren", o_BRAM_WrEn, 1);
    check("load_final_addr", o_BRAM_Addr, VW - 1);
    check("load_final_din", o_BRAM_Din, VW);
    check("load_wr_count", wr_cnt, VW);
    check("load_exit_thr_ready", o_Thr_Ready, 0);
    check("load_exit_stream_valid", o_Valid, 1);
    check("load_exit_no_pop", o_Src_Read, 0);

    // 978 beats from a source that has data one cycle in four
    beats = 0; cyc = 0; n_last = 0; n_pop = 0;
    while (beats < 978 && cyc < 6000) begin
      @(negedge clk);
      i_Src_Empty = ((cyc % 4) != 0); i_Core_Read = 1'b1;
      i_Src_Vector = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("stream_valid", o_Valid, !i_Src_Empty);
      check("stream_src_read", o_Src_Read, !i_Src_Empty);
      check("stream_last", o_Last, (!i_Src_Empty) && (beats == 977));
      if (o_Last) n_last++;
      if (o_Src_Read) n_pop++;
      if (!i_Src_Empty) beats++;
      cyc++;
    end
    check("stream_pop_count", n_pop, 978);
    check("stream_last_count", n_last, 1);

    // Drain five pairs with a toggling sink
    pairs = 0; cyc = 0;
    while (pairs < 5 && cyc < 100) begin
      @(negedge clk);
      i_Src_Empty = 1'b1; i_IDPair_Ready = 1'b1;
      i_Sink_Ready = cyc[0]; i_IDPair_Last = (pairs == 4);
      #1;
      check("drain_idpair_read", o_IDPair_Read, i_Sink_Ready);
      check("drain_busy", o_Busy, 1);
      check("drain_done", o_Done, 0);
      check("drain_valid", o_Valid, 0);
      if (i_Sink_Ready) pairs++;
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("run_done", o_Done, 1);
    check("run_pc", o_PairCount, 5);
    check("run_error", o_Error, 0);
    @(negedge clk);
    #1;
    check("run_done_pulse", o_Done, 0);
    check("run_idle", o_Busy, 0);

    // Reset in mid-stream, then a fresh run from beat 0
    @(negedge clk);
    i_Start = 1'b1; i_NumBeats = 32'd200;
    i_Src_Empty = 1'b0; i_Core_Read = 1'b1; i_Sink_Ready = 1'b1; i_IDPair_Ready = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    check("mid_pc", o_PairCount, 100);
    check("mid_last", o_Last, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", o_Busy, 0);     check("mid_rst_valid", o_Valid, 0);
    check("mid_rst_src_read", o_Src_Read, 0);
    check("mid_rst_idpair_read", o_IDPair_Read, 0);
    check("mid_rst_pc", o_PairCount, 0);  check("mid_rst_done", o_Done, 0);
    check("mid_rst_bram_en", o_BRAM_En, 1);
    @(negedge clk);
    rstn = 1'b1; i_Sink_Ready = 1'b0; i_IDPair_Ready = 1'b0;
    i_Start = 1'b1; i_NumBeats = 32'd2;
    @(negedge clk);
    i_Start = 1'b0;
    #1;
    check("restart_beat0_last", o_Last, 0);
    check("restart_beat0_pop", o_Src_Read, 1);
    @(negedge clk);
    #1;
    check("restart_beat1_last", o_Last, 1);
    check("restart_pc", o_PairCount, 0);
    @(negedge clk);
    i_Src_Empty = 1'b1; i_Sink_Ready = 1'b1; i_IDPair_Ready = 1'b1; i_IDPair_Last = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("restart_done", o_Done, 1);
    check("restart_pc_end", o_PairCount, 1);

`ifdef TANIMOTO_CTRL_TIMEOUT_EN
    // Drain watchdog with no pairs offered
    @(negedge clk);
    i_Start = 1'b1; i_NumBeats = 32'd1;
    @(negedge clk);
    i_Start = 1'b0; i_Src_Empty = 1'b0; i_Core_Read = 1'b1;
    @(negedge clk);
    idle_inputs();
    cyc = 0;
    #1;
    while (!o_Done && cyc < 100) begin
      check("to_error_early", o_Error, 0);
      cyc++;
      @(negedge clk);
      #1;
    end
    check("to_drain_cycles", cyc, 16);
    check("to_done", o_Done, 1);
    check("to_error", o_Error, 1);
    @(negedge clk);
    #1;
    check("to_error_sticky", o_Error, 1);
    i_Start = 1'b1; i_NumBeats = 32'd5;
    @(negedge clk);
    i_Start = 1'b0;
    #1;
    check("to_error_cleared", o_Error, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
